tlb_mp: RTL and testbench

- Next-generation parametrised TLB for the LoongArch-style core, replacing the fixed 16-entry, two-search-port TLB.
- Provides NSPORT search ports with registered 1-cycle lookup, a registered read port and a write port.
- INVTLB executes as a multi-cycle sweep FSM with a busy/done handshake.
- A free-running replacement counter supplies the TLBFILL index.
- Sits between the CSR file (write/read/invtlb) and the fetch/exe stages (search).

---
 rtl/tlb_mp.sv | 272 +++++++++++++++++++++++++++
 tb/tb_tlb_mp.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_mp.sv
// Parametrised TLB: NSPORT registered search ports, registered read port, write port,
// multi-cycle INVTLB sweep FSM and a free-running TLBFILL replacement counter.
module tlb_mp #(
  parameter int unsigned TLBNUM = 16,
  parameter int unsigned IDXW   = 4,
  parameter int unsigned NSPORT = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NSPORT-1:0]        s_req,
  input  logic [19*NSPORT-1:0]     s_vppn,
  input  logic [10*NSPORT-1:0]     s_asid,
  input  logic [NSPORT-1:0]        s_va_bit12,
  output logic [NSPORT-1:0]        s_rvalid,
  output logic [NSPORT-1:0]        s_found,
  output logic [IDXW*NSPORT-1:0]   s_index,
  output logic [20*NSPORT-1:0]     s_ppn,
  output logic [6*NSPORT-1:0]      s_ps,
  output logic [2*NSPORT-1:0]      s_mat,
  output logic [2*NSPORT-1:0]      s_plv,
  output logic [NSPORT-1:0]        s_d,
  output logic [NSPORT-1:0]        s_v,
  input  logic                     we,
  input  logic [IDXW-1:0]          w_index,
  input  logic                     w_e,
  input  logic [18:0]              w_vppn,
  input  logic [5:0]               w_ps,
  input  logic [9:0]               w_asid,
  input  logic                     w_g,
  input  logic [19:0]              w_ppn0,
  input  logic [1:0]               w_plv0,
  input  logic [1:0]               w_mat0,
  input  logic                     w_d0,
  input  logic                     w_v0,
  input  logic [19:0]              w_ppn1,
  input  logic [1:0]               w_plv1,
  input  logic [1:0]               w_mat1,
  input  logic                     w_d1,
  input  logic                     w_v1,
  input  logic                     r_req,
  input  logic [IDXW-1:0]          r_index,
  output logic                     r_e,
  output logic [18:0]              r_vppn,
  output logic [5:0]               r_ps,
  output logic [9:0]               r_asid,
  output logic                     r_g,
  output logic [19:0]              r_ppn0,
  output logic [1:0]               r_plv0,
  output logic [1:0]               r_mat0,
  output logic                     r_d0,
  output logic                     r_v0,
  output logic [19:0]              r_ppn1,
  output logic [1:0]               r_plv1,
  output logic [1:0]               r_mat1,
  output logic                     r_d1,
  output logic                     r_v1,
  input  logic                     inv_req,
  input  logic [4:0]               inv_op,
  input  logic [9:0]               inv_asid,
  input  logic [18:0]              inv_vppn,
  input  logic                     inv_va_bit12,
  output logic                     inv_busy,
  output logic                     inv_done,
  output logic                     inv_illegal,
  output logic [IDXW-1:0]          fill_index
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} inv_state_t;

  logic [TLBNUM-1:0] tlb_e;
  logic [TLBNUM-1:0] tlb_g;
  logic [18:0]       tlb_vppn [TLBNUM];
  logic [5:0]        tlb_ps   [TLBNUM];
  logic [9:0]        tlb_asid [TLBNUM];
  logic [19:0]       tlb_ppn0 [TLBNUM];
  logic [1:0]        tlb_plv0 [TLBNUM];
  logic [1:0]        tlb_mat0 [TLBNUM];
  logic              tlb_d0   [TLBNUM];
  logic              tlb_v0   [TLBNUM];
  logic [19:0]       tlb_ppn1 [TLBNUM];
  logic [1:0]        tlb_plv1 [TLBNUM];
  logic [1:0]        tlb_mat1 [TLBNUM];
  logic              tlb_d1   [TLBNUM];
  logic              tlb_v1   [TLBNUM];

  inv_state_t        state, state_nxt;
  logic [IDXW-1:0]   ptr;
  logic [4:0]        op_q;
  logic [9:0]        asid_q;
  logic [18:0]       vppn_q;
  logic              inv_pred;
  logic              inv_clr;

  logic [NSPORT-1:0] hit_found;
  logic [NSPORT-1:0] hit_odd;
  logic [IDXW-1:0]   hit_idx [NSPORT];

  logic              unused_inv_bit12;
  assign unused_inv_bit12 = inv_va_bit12;

  // Page-size-aware VPPN compare: 4KB pages use all 19 bits, 2MB pages only [18:9].
  function automatic logic va_match(input logic [18:0] ev, input logic [5:0] eps,
                                    input logic [18:0] kv);
    case (eps)
      6'd12:   return ev == kv;
      6'd21:   return ev[18:9] == kv[18:9];
      default: return 1'b0;
    endcase
  endfunction

  // Priority search: first hit from index 0 upward wins.
  always_comb begin
    hit_found = '0;
    hit_odd   = '0;
    for (int unsigned k = 0; k < NSPORT; k++) begin
      hit_idx[k] = '0;
      for (int unsigned i = 0; i < TLBNUM; i++) begin
        if (!hit_found[k] && tlb_e[i] &&
            (tlb_g[i] || tlb_asid[i] == s_asid[10*k +: 10]) &&
            va_match(tlb_vppn[i], tlb_ps[i], s_vppn[19*k +: 19])) begin
          hit_found[k] = 1'b1;
          hit_idx[k]   = IDXW'(i);
          hit_odd[k]   = (tlb_ps[i] == 6'd12) ? s_va_bit12[k] : s_vppn[19*k + 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_rvalid <= '0;
      s_found  <= '0;
      s_index  <= '0;
      s_ppn    <= '0;
      s_ps     <= '0;
      s_mat    <= '0;
      s_plv    <= '0;
      s_d      <= '0;
      s_v      <= '0;
    end else begin
      s_rvalid <= s_req;
      for (int unsigned k = 0; k < NSPORT; k++) begin
        if (s_req[k]) begin
          s_found[k]               <= hit_found[k];
          s_index[IDXW*k +: IDXW]  <= hit_idx[k];
          if (hit_found[k]) begin
            s_ps[6*k +: 6]   <= tlb_ps[hit_idx[k]];
            s_ppn[20*k +: 20] <= hit_odd[k] ? tlb_ppn1[hit_idx[k]] : tlb_ppn0[hit_idx[k]];
            s_plv[2*k +: 2]  <= hit_odd[k] ? tlb_plv1[hit_idx[k]] : tlb_plv0[hit_idx[k]];
            s_mat[2*k +: 2]  <= hit_odd[k] ? tlb_mat1[hit_idx[k]] : tlb_mat0[hit_idx[k]];
            s_d[k]           <= hit_odd[k] ? tlb_d1[hit_idx[k]]   : tlb_d0[hit_idx[k]];
            s_v[k]           <= hit_odd[k] ? tlb_v1[hit_idx[k]]   : tlb_v0[hit_idx[k]];
          end else begin
            s_ps[6*k +: 6]    <= '0;
            s_ppn[20*k +: 20] <= '0;
            s_plv[2*k +: 2]   <= '0;
            s_mat[2*k +: 2]   <= '0;
            s_d[k]            <= 1'b0;
            s_v[k]            <= 1'b0;
          end
        end
      end
    end
  end

  // The write is ordered after the sweep clear so a same-index write survives.
  always_ff @(posedge clk) begin
    if (reset) begin
      tlb_e <= '0;
    end else begin
      if (inv_clr) tlb_e[ptr] <= 1'b0;
      if (we)      tlb_e[w_index] <= w_e;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tlb_g[w_index]    <= w_g;
      tlb_vppn[w_index] <= w_vppn;
      tlb_ps[w_index]   <= w_ps;
      tlb_asid[w_index] <= w_asid;
      tlb_ppn0[w_index] <= w_ppn0;
      tlb_plv0[w_index] <= w_plv0;
      tlb_mat0[w_index] <= w_mat0;
      tlb_d0[w_index]   <= w_d0;
      tlb_v0[w_index]   <= w_v0;
      tlb_ppn1[w_index] <= w_ppn1;
      tlb_plv1[w_index] <= w_plv1;
      tlb_mat1[w_index] <= w_mat1;
      tlb_d1[w_index]   <= w_d1;
      tlb_v1[w_index]   <= w_v1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_e <= 1'b0;  r_vppn <= '0; r_ps <= '0;   r_asid <= '0; r_g <= 1'b0;
      r_ppn0 <= '0; r_plv0 <= '0; r_mat0 <= '0; r_d0 <= 1'b0; r_v0 <= 1'b0;
      r_ppn1 <= '0; r_plv1 <= '0; r_mat1 <= '0; r_d1 <= 1'b0; r_v1 <= 1'b0;
    end else if (r_req) begin
      r_e    <= tlb_e[r_index];    r_vppn <= tlb_vppn[r_index];
      r_ps   <= tlb_ps[r_index];   r_asid <= tlb_asid[r_index];
      r_g    <= tlb_g[r_index];
      r_ppn0 <= tlb_ppn0[r_index]; r_plv0 <= tlb_plv0[r_index];
      r_mat0 <= tlb_mat0[r_index]; r_d0   <= tlb_d0[r_index];
      r_v0   <= tlb_v0[r_index];
      r_ppn1 <= tlb_ppn1[r_index]; r_plv1 <= tlb_plv1[r_index];
      r_mat1 <= tlb_mat1[r_index]; r_d1   <= tlb_d1[r_index];
      r_v1   <= tlb_v1[r_index];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) fill_index <= '0;
    else       fill_index <= fill_index + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr    <= '0;
      op_q   <= '0;
      asid_q <= '0;
      vppn_q <= '0;
    end else if (state == IDLE && inv_req) begin
      ptr    <= '0;
      op_q   <= inv_op;
      asid_q <= inv_asid;
      vppn_q <= inv_vppn;
    end else if (state == SWEEP) begin
      ptr <= ptr + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (inv_req) state_nxt = (inv_op > 5'd6) ? DONE : SWEEP;
      SWEEP:   if (ptr == IDXW'(TLBNUM-1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    inv_busy    = (state == SWEEP);
    inv_done    = (state == DONE);
    inv_illegal = (state == DONE) && (op_q > 5'd6);
  end

  always_comb begin
    logic asid_hit, va_hit, gbit;
    asid_hit = (tlb_asid[ptr] == asid_q);
    va_hit   = va_match(tlb_vppn[ptr], tlb_ps[ptr], vppn_q);
    gbit     = tlb_g[ptr];
    case (op_q)
      5'd0, 5'd1: inv_pred = 1'b1;
      5'd2:       inv_pred = gbit;
      5'd3:       inv_pred = !gbit;
      5'd4:       inv_pred = !gbit && asid_hit;
      5'd5:       inv_pred = !gbit && asid_hit && va_hit;
      5'd6:       inv_pred = (gbit || asid_hit) && va_hit;
      default:    inv_pred = 1'b0;
    endcase
    inv_clr = (state == SWEEP) && inv_pred;
  end

endmodule

// File: tb/tb_tlb_mp.sv
// Directed self-checking bench for tlb_mp: search, read, write, INVTLB sweep and fill counter.
module tb_tlb_mp;
  localparam int TLBNUM = 16;
  localparam int IDXW   = 4;
  localparam int NSPORT = 2;

  logic clk, reset;
  logic [NSPORT-1:0] s_req, s_va_bit12, s_rvalid, s_found, s_d, s_v;
  logic [19*NSPORT-1:0] s_vppn;
  logic [10*NSPORT-1:0] s_asid;
  logic [IDXW*NSPORT-1:0] s_index;
  logic [20*NSPORT-1:0] s_ppn;
  logic [6*NSPORT-1:0] s_ps;
  logic [2*NSPORT-1:0] s_mat, s_plv;
  logic we, w_e, w_g, w_d0, w_v0, w_d1, w_v1;
  logic [IDXW-1:0] w_index, r_index, fill_index;
  logic [18:0] w_vppn, r_vppn, inv_vppn;
  logic [5:0] w_ps, r_ps;
  logic [9:0] w_asid, r_asid, inv_asid;
  logic [19:0] w_ppn0, w_ppn1, r_ppn0, r_ppn1;
  logic [1:0] w_plv0, w_mat0, w_plv1, w_mat1, r_plv0, r_mat0, r_plv1, r_mat1;
  logic r_req, r_e, r_g, r_d0, r_v0, r_d1, r_v1;
  logic inv_req, inv_va_bit12, inv_busy, inv_done, inv_illegal;
  logic [4:0] inv_op;

  int n_checks = 0;
  int n_fail   = 0;

  tlb_mp #(.TLBNUM(TLBNUM), .IDXW(IDXW), .NSPORT(NSPORT)) dut (
    .clk(clk), .reset(reset),
    .s_req(s_req), .s_vppn(s_vppn), .s_asid(s_asid), .s_va_bit12(s_va_bit12),
    .s_rvalid(s_rvalid), .s_found(s_found), .s_index(s_index), .s_ppn(s_ppn),
    .s_ps(s_ps), .s_mat(s_mat), .s_plv(s_plv), .s_d(s_d), .s_v(s_v),
    .we(we), .w_index(w_index), .w_e(w_e), .w_vppn(w_vppn), .w_ps(w_ps),
    .w_asid(w_asid), .w_g(w_g), .w_ppn0(w_ppn0), .w_plv0(w_plv0), .w_mat0(w_mat0),
    .w_d0(w_d0), .w_v0(w_v0), .w_ppn1(w_ppn1), .w_plv1(w_plv1), .w_mat1(w_mat1),
    .w_d1(w_d1), .w_v1(w_v1),
    .r_req(r_req), .r_index(r_index), .r_e(r_e), .r_vppn(r_vppn), .r_ps(r_ps),
    .r_asid(r_asid), .r_g(r_g), .r_ppn0(r_ppn0), .r_plv0(r_plv0), .r_mat0(r_mat0),
    .r_d0(r_d0), .r_v0(r_v0), .r_ppn1(r_ppn1), .r_plv1(r_plv1), .r_mat1(r_mat1),
    .r_d1(r_d1), .r_v1(r_v1),
    .inv_req(inv_req), .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn),
    .inv_va_bit12(inv_va_bit12), .inv_busy(inv_busy), .inv_done(inv_done),
    .inv_illegal(inv_illegal), .fill_index(fill_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Entry page attributes are fixed: even page plv=1 mat=1 d=1 v=1, odd page plv=3 mat=2 d=0 v=1.
  task automatic set_write(input logic [3:0] idx, input logic e, input logic [18:0] vppn,
                           input logic [5:0] ps, input logic [9:0] asid, input logic g,
                           input logic [19:0] ppn0, input logic [19:0] ppn1);
    we = 1'b1; w_index = idx; w_e = e; w_vppn = vppn; w_ps = ps; w_asid = asid; w_g = g;
    w_ppn0 = ppn0; w_plv0 = 2'd1; w_mat0 = 2'd1; w_d0 = 1'b1; w_v0 = 1'b1;
    w_ppn1 = ppn1; w_plv1 = 2'd3; w_mat1 = 2'd2; w_d1 = 1'b0; w_v1 = 1'b1;
  endtask

  task automatic write_entry(input logic [3:0] idx, input logic e, input logic [18:0] vppn,
                             input logic [5:0] ps, input logic [9:0] asid, input logic g,
                             input logic [19:0] ppn0, input logic [19:0] ppn1);
    set_write(idx, e, vppn, ps, asid, g, ppn0, ppn1);
    step;
    we = 1'b0;
  endtask

  task automatic set_search(input int p, input logic [18:0] vppn, input logic [9:0] asid,
                            input logic bit12);
    s_req[p] = 1'b1;
    s_vppn[19*p +: 19] = vppn;
    s_asid[10*p +: 10] = asid;
    s_va_bit12[p] = bit12;
  endtask

  task automatic search0(input logic [18:0] vppn, input logic [9:0] asid, input logic bit12);
    set_search(0, vppn, asid, bit12);
    step;
    s_req = '0;
  endtask

  task automatic run_inv(input logic [4:0] op, input logic [9:0] asid, input logic [18:0] vppn,
                         output int cyc);
    inv_req = 1'b1; inv_op = op; inv_asid = asid; inv_vppn = vppn;
    step;
    inv_req = 1'b0;
    cyc = 0;
    while (!inv_done && cyc < 100) begin
      step;
      cyc++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step; step;
    n_checks++; if (inv_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", inv_busy); end
    n_checks++; if (inv_done !== 1'b0 || inv_illegal !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b%b want 00", inv_done, inv_illegal); end
    n_checks++; if (s_rvalid !== 2'b00 || s_found !== 2'b00) begin n_fail++; $display("FAIL rst_search got %b/%b want 00/00", s_rvalid, s_found); end
    n_checks++; if (s_ppn !== '0 || s_index !== '0) begin n_fail++; $display("FAIL rst_sfields got %h/%h want 0", s_ppn, s_index); end
    n_checks++; if (r_e !== 1'b0 || r_vppn !== '0) begin n_fail++; $display("FAIL rst_read got %b/%h want 0", r_e, r_vppn); end
  endtask

  task automatic test_fill_index;
    n_checks++; if (fill_index !== 4'd0) begin n_fail++; $display("FAIL fill_rst got %0d want 0", fill_index); end
    reset = 1'b0;
    for (int i = 1; i <= TLBNUM; i++) begin
      step;
      n_checks++;
      if (fill_index !== 4'(i % TLBNUM)) begin n_fail++; $display("FAIL fill_seq got %0d want %0d", fill_index, i % TLBNUM); end
    end
  endtask

  task automatic test_search_basic;
    write_entry(4'd3, 1'b1, 19'h00010, 6'd12, 10'd5, 1'b0, 20'h111, 20'h222);
    search0(19'h00010, 10'd6, 1'b1);
    n_checks++; if (s_found[0] !== 1'b0 || s_ppn[19:0] !== 20'h0 || s_index[3:0] !== 4'd0) begin n_fail++; $display("FAIL asid_miss got f=%b ppn=%h idx=%0d want 0/0/0", s_found[0], s_ppn[19:0], s_index[3:0]); end
    search0(19'h00010, 10'd5, 1'b1);
    n_checks++; if (s_rvalid !== 2'b01) begin n_fail++; $display("FAIL rvalid got %b want 01", s_rvalid); end
    n_checks++; if (s_found[0] !== 1'b1 || s_index[3:0] !== 4'd3) begin n_fail++; $display("FAIL hit_odd got f=%b idx=%0d want 1/3", s_found[0], s_index[3:0]); end
    n_checks++; if (s_ppn[19:0] !== 20'h222 || s_plv[1:0] !== 2'd3 || s_mat[1:0] !== 2'd2 || s_d[0] !== 1'b0 || s_ps[5:0] !== 6'd12) begin n_fail++; $display("FAIL odd_fields got ppn=%h plv=%0d mat=%0d d=%b ps=%0d want 222/3/2/0/12", s_ppn[19:0], s_plv[1:0], s_mat[1:0], s_d[0], s_ps[5:0]); end
    step;
    n_checks++; if (s_rvalid[0] !== 1'b0 || s_found[0] !== 1'b1 || s_ppn[19:0] !== 20'h222) begin n_fail++; $display("FAIL hold got rv=%b f=%b ppn=%h want 0/1/222", s_rvalid[0], s_found[0], s_ppn[19:0]); end
    search0(19'h00010, 10'd5, 1'b0);
    n_checks++; if (s_ppn[19:0] !== 20'h111 || s_plv[1:0] !== 2'd1 || s_d[0] !== 1'b1) begin n_fail++; $display("FAIL even_fields got ppn=%h plv=%0d d=%b want 111/1/1", s_ppn[19:0], s_plv[1:0], s_d[0]); end
    r_req = 1'b1; r_index = 4'd3;
    step;
    r_req = 1'b0; r_index = 4'd0;
    n_checks++; if (r_e !== 1'b1 || r_vppn !== 19'h10 || r_asid !== 10'd5 || r_ppn1 !== 20'h222 || r_ps !== 6'd12) begin n_fail++; $display("FAIL read got e=%b vppn=%h asid=%0d ppn1=%h ps=%0d want 1/10/5/222/12", r_e, r_vppn, r_asid, r_ppn1, r_ps); end
    step;
    n_checks++; if (r_vppn !== 19'h10) begin n_fail++; $display("FAIL read_hold got %h want 10", r_vppn); end
  endtask

  task automatic test_huge_page;
    write_entry(4'd1, 1'b1, 19'h7FE00, 6'd21, 10'd0, 1'b1, 20'h333, 20'h444);
    search0(19'h7FF23, 10'h3AB, 1'b0);
    n_checks++; if (s_found[0] !== 1'b1 || s_index[3:0] !== 4'd1 || s_ppn[19:0] !== 20'h444 || s_ps[5:0] !== 6'd21) begin n_fail++; $display("FAIL huge_hit got f=%b idx=%0d ppn=%h ps=%0d want 1/1/444/21", s_found[0], s_index[3:0], s_ppn[19:0], s_ps[5:0]); end
    write_entry(4'd0, 1'b1, 19'h7FE00, 6'd21, 10'd0, 1'b1, 20'h000, 20'h555);
    search0(19'h7FF23, 10'h3AB, 1'b0);
    n_checks++; if (s_index[3:0] !== 4'd0 || s_ppn[19:0] !== 20'h555) begin n_fail++; $display("FAIL lowest_idx got idx=%0d ppn=%h want 0/555", s_index[3:0], s_ppn[19:0]); end
    set_write(4'd0, 1'b1, 19'h7FE00, 6'd21, 10'd0, 1'b1, 20'h000, 20'h666);
    set_search(0, 19'h7FF23, 10'h3AB, 1'b0);
    step;
    we = 1'b0; s_req = '0;
    n_checks++; if (s_ppn[19:0] !== 20'h555) begin n_fail++; $display("FAIL old_contents got %h want 555", s_ppn[19:0]); end
    search0(19'h7FF23, 10'h3AB, 1'b0);
    n_checks++; if (s_ppn[19:0] !== 20'h666) begin n_fail++; $display("FAIL new_contents got %h want 666", s_ppn[19:0]); end
    write_entry(4'd2, 1'b1, 19'h00020, 6'd13, 10'd0, 1'b1, 20'h777, 20'h888);
    search0(19'h00020, 10'd0, 1'b0);
    n_checks++; if (s_found[0] !== 1'b0) begin n_fail++; $display("FAIL ps13_miss got %b want 0", s_found[0]); end
  endtask

  task automatic test_inv_global;
    for (int i = 0; i < TLBNUM; i++)
      write_entry(4'(i), 1'b1, 19'(32'h100 + i), 6'd12, 10'd7, 1'(i % 2), 20'(i), 20'(32'h100 + i));
    inv_req = 1'b1; inv_op = 5'd2; inv_asid = 10'd0; inv_vppn = 19'd0;
    step;
    inv_req = 1'b0;
    for (int c = 0; c < TLBNUM; c++) begin
      n_checks++; if (inv_busy !== 1'b1 || inv_done !== 1'b0) begin n_fail++; $display("FAIL sweep_busy c=%0d got busy=%b done=%b want 1/0", c, inv_busy, inv_done); end
      step;
    end
    n_checks++; if (inv_done !== 1'b1 || inv_busy !== 1'b0 || inv_illegal !== 1'b0) begin n_fail++; $display("FAIL sweep_done got done=%b busy=%b ill=%b want 1/0/0", inv_done, inv_busy, inv_illegal); end
    step;
    n_checks++; if (inv_done !== 1'b0) begin n_fail++; $display("FAIL done_pulse got %b want 0", inv_done); end
    for (int i = 0; i < TLBNUM; i++) begin
      logic exp;
      exp = (i % 2 == 0);
      search0(19'(32'h100 + i), 10'd7, 1'b0);
      n_checks++;
      if (s_found[0] !== exp || (exp && s_index[3:0] !== 4'(i))) begin n_fail++; $display("FAIL op2_entry%0d got f=%b idx=%0d want f=%b", i, s_found[0], s_index[3:0], exp); end
    end
  endtask

  task automatic test_illegal;
    int cyc;
    inv_req = 1'b1; inv_op = 5'd7;
    step;
    inv_req = 1'b0;
    n_checks++; if (inv_done !== 1'b1 || inv_illegal !== 1'b1 || inv_busy !== 1'b0) begin n_fail++; $display("FAIL illegal got done=%b ill=%b busy=%b want 1/1/0", inv_done, inv_illegal, inv_busy); end
    step;
    n_checks++; if (inv_done !== 1'b0 || inv_illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_pulse got %b%b want 00", inv_done, inv_illegal); end
    search0(19'h104, 10'd7, 1'b0);
    n_checks++; if (s_found[0] !== 1'b1 || s_index[3:0] !== 4'd4) begin n_fail++; $display("FAIL illegal_nochange got f=%b idx=%0d want 1/4", s_found[0], s_index[3:0]); end
    run_inv(5'd5, 10'd7, 19'h106, cyc);
    n_checks++; if (cyc !== TLBNUM) begin n_fail++; $display("FAIL op5_latency got %0d want %0d", cyc, TLBNUM); end
    step;
    search0(19'h106, 10'd7, 1'b0);
    n_checks++; if (s_found[0] !== 1'b0) begin n_fail++; $display("FAIL op5_clear got %b want 0", s_found[0]); end
    search0(19'h104, 10'd7, 1'b0);
    n_checks++; if (s_found[0] !== 1'b1) begin n_fail++; $display("FAIL op5_keep got %b want 1", s_found[0]); end
  endtask

  task automatic test_ignored_req;
    int busy_cnt, done_cnt;
    busy_cnt = 0; done_cnt = 0;
    inv_req = 1'b1; inv_op = 5'd4; inv_asid = 10'd9;
    step;
    inv_req = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (inv_busy) busy_cnt++;
      if (inv_done) done_cnt++;
      if (c == 3 || c == 16) begin inv_req = 1'b1; inv_op = 5'd0; end
      else inv_req = 1'b0;
      step;
    end
    inv_req = 1'b0;
    n_checks++; if (busy_cnt !== TLBNUM || done_cnt !== 1) begin n_fail++; $display("FAIL ignored_req got busy=%0d done=%0d want %0d/1", busy_cnt, done_cnt, TLBNUM); end
    search0(19'h104, 10'd7, 1'b0);
    n_checks++; if (s_found[0] !== 1'b1) begin n_fail++; $display("FAIL ignored_nochange got %b want 1", s_found[0]); end
  endtask

  task automatic test_sweep_write;
    int done_cnt;
    write_entry(4'd15, 1'b0, 19'h20F, 6'd12, 10'd7, 1'b0, 20'h0, 20'h0);
    inv_req = 1'b1; inv_op = 5'd0;
    step;
    inv_req = 1'b0;
    for (int c = 0; c < TLBNUM; c++) begin
      if (c == 5) set_write(4'd15, 1'b1, 19'h20F, 6'd12, 10'd7, 1'b0, 20'hF0, 20'hF1);
      else we = 1'b0;
      step;
    end
    we = 1'b0;
    n_checks++; if (inv_done !== 1'b1) begin n_fail++; $display("FAIL sw_done got %b want 1", inv_done); end
    step;
    search0(19'h20F, 10'd7, 1'b0);
    n_checks++; if (s_found[0] !== 1'b0) begin n_fail++; $display("FAIL early_write_cleared got %b want 0", s_found[0]); end
    write_entry(4'd14, 1'b1, 19'h20E, 6'd12, 10'd7, 1'b0, 20'hE0, 20'hE1);
    inv_req = 1'b1; inv_op = 5'd0;
    step;
    inv_req = 1'b0;
    for (int c = 0; c < TLBNUM; c++) begin
      if (c == 15) set_write(4'd15, 1'b1, 19'h20F, 6'd12, 10'd7, 1'b0, 20'hF0, 20'hF1);
      else we = 1'b0;
      step;
    end
    we = 1'b0;
    step;
    search0(19'h20F, 10'd7, 1'b0);
    n_checks++; if (s_found[0] !== 1'b1 || s_index[3:0] !== 4'd15) begin n_fail++; $display("FAIL write_wins got f=%b idx=%0d want 1/15", s_found[0], s_index[3:0]); end
    search0(19'h20E, 10'd7, 1'b0);
    n_checks++; if (s_found[0] !== 1'b0) begin n_fail++; $display("FAIL op0_clear got %b want 0", s_found[0]); end
    inv_req = 1'b1; inv_op = 5'd4; inv_asid = 10'd9;
    step;
    inv_req = 1'b0;
    for (int c = 0; c < 5; c++) step;
    reset = 1'b1;
    step;
    reset = 1'b0;
    n_checks++; if (inv_busy !== 1'b0 || inv_done !== 1'b0) begin n_fail++; $display("FAIL abort got busy=%b done=%b want 0/0", inv_busy, inv_done); end
    done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (inv_done) done_cnt++;
      step;
    end
    n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL abort_nodone got %0d want 0", done_cnt); end
    search0(19'h20F, 10'd7, 1'b0);
    n_checks++; if (s_found[0] !== 1'b0) begin n_fail++; $display("FAIL reset_clears_e got %b want 0", s_found[0]); end
  endtask

  task automatic test_two_ports;
    write_entry(4'd5, 1'b1, 19'h00050, 6'd12, 10'd3, 1'b0, 20'h0A4, 20'h0A5);
    write_entry(4'd9, 1'b1, 19'h2A000, 6'd21, 10'd0, 1'b1, 20'h0B9, 20'h0BA);
    set_search(0, 19'h00050, 10'd3, 1'b1);
    set_search(1, 19'h2A0FF, 10'h155, 1'b0);
    step;
    s_req = '0;
    n_checks++; if (s_rvalid !== 2'b11 || s_found !== 2'b11) begin n_fail++; $display("FAIL dual_valid got rv=%b f=%b want 11/11", s_rvalid, s_found); end
    n_checks++; if (s_index[3:0] !== 4'd5 || s_index[7:4] !== 4'd9) begin n_fail++; $display("FAIL dual_index got %0d/%0d want 5/9", s_index[3:0], s_index[7:4]); end
    n_checks++; if (s_ppn[19:0] !== 20'h0A5 || s_ppn[39:20] !== 20'h0B9) begin n_fail++; $display("FAIL dual_ppn got %h/%h want 0A5/0B9", s_ppn[19:0], s_ppn[39:20]); end
    n_checks++; if (s_ps[11:6] !== 6'd21 || s_plv[3:2] !== 2'd1 || s_plv[1:0] !== 2'd3) begin n_fail++; $display("FAIL dual_attr got ps1=%0d plv1=%0d plv0=%0d want 21/1/3", s_ps[11:6], s_plv[3:2], s_plv[1:0]); end
  endtask

  initial begin
    reset = 1'b1;
    s_req = '0; s_vppn = '0; s_asid = '0; s_va_bit12 = '0;
    we = 1'b0; w_index = '0; w_e = 1'b0; w_vppn = '0; w_ps = '0; w_asid = '0; w_g = 1'b0;
    w_ppn0 = '0; w_plv0 = '0; w_mat0 = '0; w_d0 = 1'b0; w_v0 = 1'b0;
    w_ppn1 = '0; w_plv1 = '0; w_mat1 = '0; w_d1 = 1'b0; w_v1 = 1'b0;
    r_req = 1'b0; r_index = '0;
    inv_req = 1'b0; inv_op = '0; inv_asid = '0; inv_vppn = '0; inv_va_bit12 = 1'b0;
    test_reset;
    test_fill_index;
    test_search_basic;
    test_huge_page;
    test_inv_global;
    test_illegal;
    test_ignored_req;
    test_sweep_write;
    test_two_ports;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
